pingpong_readout_ctrl: RTL and testbench
========================================

# pingpong_readout_ctrl

Read-side sequencer for the ping-pong sample RAM. It waits for a filled half-buffer, then reads every word of that half in address order over a 1-cycle-latency synchronous read port. Each word is forwarded on a valid/ready stream to the downstream consumer (UART dump, FFT front-end). When the last word has been accepted, it pulses the acknowledge that releases the half back to the writer. It sits between the ping-pong RAM's read port and any single downstream consumer, in the mic-sampling clock domain.

## Interface
- DEPTH, 512, words per half-buffer; must be ≥2.
- DATA_W, 16, sample word width.
- ADDR_W, $clog2(DEPTH), read address width.
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  reset; asynchronous and active-low.
- enable_i  in  1  permits starting a new drain; an ongoing drain always completes.
- buffer_ready_i  in  1  level from RAM: a filled half awaits readout.
- rd_en_o  out  1  RAM read strobe.
- rd_addr_o  out  ADDR_W  word index within the current half.
- rd_data_i  in  DATA_W  RAM data, valid the cycle after rd_en_o.
- ack_o  out  1  one-cycle pulse: the half has been fully consumed.
- m_valid_o  out  1  stream word valid.
- m_data_o  out  DATA_W  stream word.
- m_last_o  out  1  marks word DEPTH-1.
- m_ready_i  in  1  downstream accepts the word.
- busy_o  out  1  high in every state except IDLE.
- overrun_cnt_o  out  8  saturating count of overruns.

## Operation
- FSM states: IDLE, FETCH, LATCH, SEND, ACK, GAP.
- IDLE: if buffer_ready_i && enable_i, clear idx to 0 and go to FETCH.
- FETCH: rd_en_o=1, rd_addr_o=idx; go to LATCH.
- LATCH: register rd_data_i into m_data_o, set m_last_o=(idx==DEPTH-1); go to SEND.
- SEND: m_valid_o=1. Stay in SEND until m_valid_o && m_ready_i. On that handshake: if idx==DEPTH-1 go to ACK, else idx+1 and go to FETCH.
- ACK: ack_o=1 for exactly one cycle; go to GAP.
- GAP: buffer_ready_i is ignored for one cycle, giving the RAM time to drop or refresh it; go to IDLE.
- idx is ADDR_W bits wide and never wraps inside a drain; it is reloaded to 0 on every start.
- m_data_o and m_last_o are stable while m_valid_o=1 && !m_ready_i.
- m_ready_i is a don't-care outside SEND.
- Overrun: a rising edge of buffer_ready_i (registered previous value 0, current value 1) while state!=IDLE increments overrun_cnt_o. The count saturates at 255 and is cleared only by reset.
- Dropping enable_i mid-drain has no effect on the current drain. The next start is blocked while enable_i=0.
- Reset mid-drain: return to IDLE immediately, no ack_o is issued, and the RAM half stays unacknowledged.

## Timing
- Reset values: rd_en_o=0, rd_addr_o=0, ack_o=0, m_valid_o=0, m_data_o=0, m_last_o=0, busy_o=0, overrun_cnt_o=0.
- Start: buffer_ready_i high in IDLE at edge N → rd_en_o high in cycle N+1 → m_valid_o high from cycle N+3.
- Per word: minimum 3 cycles (FETCH, LATCH, SEND) with m_ready_i held high; each stall cycle adds 1.
- Full drain with no stalls: 3·DEPTH cycles from first rd_en_o to the cycle before ack_o. ack_o follows the cycle after the last handshake. IDLE is re-entered 2 cycles after the last handshake.
- Outputs in FETCH, SEND and ACK are decoded from registered state; m_data_o and m_last_o are registered.

## Configuration
- PP_RDCTRL_OVERRUN_EN defined: the edge detector and saturating counter are built as specified.
- PP_RDCTRL_OVERRUN_EN undefined: no counter logic is built and overrun_cnt_o is tied to 8'd0.

## Test plan
- Basic drain: DEPTH=4, RAM model holds {0x1111, 0x2222, 0x3333, 0x4444}, m_ready_i=1. Pulse buffer_ready_i → stream 0x1111..0x4444 with m_last_o only on 0x4444; ack_o is exactly one pulse, 1 cycle after the last handshake; rd_addr_o reads 0,1,2,3.
- Backpressure: m_ready_i low for 5 cycles during word 2 → m_data_o stays 0x3333 and stable throughout; no extra rd_en_o is issued; total drain takes 12+5 cycles.
- Gate: enable_i=0 with buffer_ready_i=1 for 20 cycles → busy_o stays 0 and no rd_en_o. Raising enable_i → rd_en_o in the next cycle.
- Overrun: toggle buffer_ready_i 0→1 three times during a drain → overrun_cnt_o=3. Force 300 edges → overrun_cnt_o=255. With the macro undefined, overrun_cnt_o stays 0.
- Reset mid-drain: assert rst_ni low after word 1 is accepted → all outputs at reset values asynchronously and no ack_o. After release with buffer_ready_i=1 → drain restarts at rd_addr_o=0.
- Back-to-back halves: buffer_ready_i stays high through ACK/GAP (next half full) → the second drain starts 2 cycles after the last handshake and the overrun count is unchanged.

Source files
------------

// File: rtl/pingpong_readout_ctrl.sv
// pingpong_readout_ctrl: read-side sequencer for the ping-pong sample RAM.
// Waits for a filled half, reads each word over a 1-cycle-latency RAM port,
// forwards it on a valid/ready stream and pulses ack_o once the last word
// has been accepted.
//
// Optional build macro: PP_RDCTRL_OVERRUN_EN
//   defined   -> buffer_ready_i rising-edge detector and saturating overrun counter
//   undefined -> no overrun logic, overrun_cnt_o tied to zero
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for buffer_ready_i && enable_i
// FETCH | read strobe for word idx
// LATCH | RAM data arrives, captured into the stream register
// SEND  | word offered downstream until accepted
// ACK   | one-cycle release of the half back to the writer
// GAP   | one cycle in which buffer_ready_i is ignored
module pingpong_readout_ctrl #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              buffer_ready_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              ack_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic [7:0]        overrun_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_ACK,
    S_GAP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              last_word;
  logic              start;
  logic              advance;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  assign last_word = (idx == ADDR_W'(DEPTH - 1));

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode and state-decoded outputs
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    advance   = 1'b0;
    rd_en_o   = 1'b0;
    m_valid_o = 1'b0;
    ack_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (buffer_ready_i && enable_i) begin
          start     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en_o   = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        m_valid_o = 1'b1;
        if (m_ready_i) begin
          if (last_word) begin
            state_nxt = S_ACK;
          end else begin
            advance   = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_ACK: begin
        ack_o     = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // word index: reloaded on every start, stepped after each non-final handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (advance) begin
      idx <= idx + ADDR_W'(1);
    end
  end

  // stream register: loaded only in LATCH so it holds steady through stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      last_q <= 1'b0;
    end else if (state == S_LATCH) begin
      data_q <= rd_data_i;
      last_q <= last_word;
    end
  end

  assign rd_addr_o = idx;
  assign m_data_o  = data_q;
  assign m_last_o  = last_q;
  assign busy_o    = (state != S_IDLE);

`ifdef PP_RDCTRL_OVERRUN_EN
  logic       ready_q;
  logic [7:0] ovr_cnt;

  // a new half arriving while a drain is in flight is an overrun
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      ovr_cnt <= 8'd0;
    end else begin
      ready_q <= buffer_ready_i;
      if (buffer_ready_i && !ready_q && (state != S_IDLE) && (ovr_cnt != 8'hFF)) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end
  end

  assign overrun_cnt_o = ovr_cnt;
`else
  assign overrun_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pingpong_readout_ctrl.sv
// Testbench for pingpong_readout_ctrl with DEPTH=4. A small RAM model feeds
// the read port; expected streams, timings and overrun counts come from the
// behavioural rules of the block, not from its internals.
module tb_pingpong_readout_ctrl;

  localparam int DEPTH     = 4;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int DRAIN_MAX = 1000;
`ifdef PP_RDCTRL_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              buffer_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ack;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic [7:0]        ovr;

  logic [DATA_W-1:0] mem [DEPTH];
  int                checks   = 0;
  int                failures = 0;
  int                exp_ovr  = 0;

  pingpong_readout_ctrl #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .buffer_ready_i(buffer_ready),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .rd_data_i     (rd_data),
    .ack_o         (ack),
    .m_valid_o     (m_valid),
    .m_data_o      (m_data),
    .m_last_o      (m_last),
    .m_ready_i     (m_ready),
    .busy_o        (busy),
    .overrun_cnt_o (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: synchronous read, data one cycle after the strobe
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_mem(input bit fixed);
    for (int i = 0; i < DEPTH; i++) begin
      if (fixed) mem[i] = DATA_W'(16'h1111 * (i + 1));
      else       mem[i] = DATA_W'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (rd_en !== 1'b0 || rd_addr !== '0 || ack !== 1'b0 || m_valid !== 1'b0 ||
        m_data !== '0 || m_last !== 1'b0 || busy !== 1'b0 || ovr !== 8'd0) begin
      failures++;
      $display("FAIL %s: rd_en=%b rd_addr=%0d ack=%b valid=%b data=%h last=%b busy=%b ovr=%0d, required all zero",
               tag, rd_en, rd_addr, ack, m_valid, m_data, m_last, busy, ovr);
    end
  endtask

  // One full drain, called at posedge+2. Cycle c is sampled at its negedge.
  task automatic drain(input string tag, input int exp_first, input int stall_pct,
                       input int stall_s, input int stall_len, input int n_tog,
                       input bit keep_ready, input bit drop_en, input int exp_total);
    logic [ADDR_W-1:0] q_addr[$];
    logic [DATA_W-1:0] q_data[$];
    logic              q_last[$];
    int first_rd = -1, hs_c = -1, ack_c = -1, ack_n = 0, stalls = 0, unstable = 0;
    bit prev_stall = 1'b0, done = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    logic pl = 1'b0;
    logic busy_end = 1'b1;
    int total;
    for (int c = 0; c < DRAIN_MAX; c++) begin
      buffer_ready = keep_ready || (c == 0) || (c >= 2 && c < 2 + 2 * n_tog && (c % 2) == 1);
      enable       = drop_en ? (c < 2) : 1'b1;
      m_ready      = !(c >= stall_s && c < stall_s + stall_len) &&
                     ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      if (rd_en) begin
        if (first_rd < 0) first_rd = c;
        q_addr.push_back(rd_addr);
      end
      if (prev_stall && (!m_valid || m_data !== pd || m_last !== pl)) unstable++;
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (m_valid && !m_ready) stalls++;
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        hs_c = c;
      end
      if (ack) begin
        ack_n++;
        if (ack_c < 0) ack_c = c;
      end
      if (ack_c >= 0 && c == ack_c + 2) begin
        busy_end = busy;
        done = 1'b1;
      end
      @(posedge clk); #2;
      if (done) break;
    end
    buffer_ready = keep_ready;
    enable = 1'b1;

    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: no ack within %0d cycles", tag, DRAIN_MAX);
      return;
    end
    checks++;
    if (first_rd != exp_first) begin
      failures++;
      $display("FAIL %s_start: first rd_en at cycle %0d, required %0d", tag, first_rd, exp_first);
    end
    checks++;
    if (q_addr.size() != DEPTH) begin
      failures++;
      $display("FAIL %s_reads: %0d read strobes, required %0d", tag, q_addr.size(), DEPTH);
    end
    for (int i = 0; i < q_addr.size() && i < DEPTH; i++) begin
      checks++;
      if (q_addr[i] !== ADDR_W'(i)) begin
        failures++;
        $display("FAIL %s_addr%0d: got %0d required %0d", tag, i, q_addr[i], i);
      end
    end
    checks++;
    if (q_data.size() != DEPTH) begin
      failures++;
      $display("FAIL %s_words: %0d handshakes, required %0d", tag, q_data.size(), DEPTH);
    end
    for (int i = 0; i < q_data.size() && i < DEPTH; i++) begin
      checks++;
      if (q_data[i] !== mem[i] || q_last[i] !== (i == DEPTH - 1)) begin
        failures++;
        $display("FAIL %s_word%0d: got data=%h last=%b required data=%h last=%b",
                 tag, i, q_data[i], q_last[i], mem[i], (i == DEPTH - 1));
      end
    end
    checks++;
    if (ack_n != 1) begin
      failures++;
      $display("FAIL %s_ack_count: got %0d pulses required 1", tag, ack_n);
    end
    checks++;
    if (ack_c != hs_c + 1) begin
      failures++;
      $display("FAIL %s_ack_time: ack at %0d, last handshake at %0d, required handshake+1", tag, ack_c, hs_c);
    end
    total = ack_c - first_rd;
    checks++;
    if (total != ((exp_total >= 0) ? exp_total : 3 * DEPTH + stalls)) begin
      failures++;
      $display("FAIL %s_duration: got %0d cycles required %0d (stalls=%0d)",
               tag, total, (exp_total >= 0) ? exp_total : 3 * DEPTH + stalls, stalls);
    end
    checks++;
    if (unstable != 0) begin
      failures++;
      $display("FAIL %s_stall_hold: %0d stall cycles changed data, required 0", tag, unstable);
    end
    checks++;
    if (busy_end !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b two cycles after ack, required 0", tag, busy_end);
    end
    exp_ovr = OVR_EN ? ((exp_ovr + n_tog > 255) ? 255 : exp_ovr + n_tog) : 0;
    checks++;
    if (ovr !== 8'(exp_ovr)) begin
      failures++;
      $display("FAIL %s_overrun: got %0d required %0d", tag, ovr, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    buffer_ready = 1'b0;
    m_ready = 1'b0;
    rd_data = '0;
    fill_mem(1'b1);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_ready: busy=%b rd_en=%b required 0 0", busy, rd_en);
    end
    @(posedge clk); #2;
    exp_ovr = 0;
  endtask

  task automatic test_basic();
    fill_mem(1'b1);
    drain("basic", 1, 0, 0, 0, 0, 1'b0, 1'b0, 3 * DEPTH);
  endtask

  task automatic test_backpressure();
    fill_mem(1'b1);
    drain("backpressure", 1, 0, 9, 5, 0, 1'b0, 1'b0, 3 * DEPTH + 5);
  endtask

  task automatic test_gate();
    int viol = 0;
    enable = 1'b0;
    buffer_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || rd_en !== 1'b0) viol++;
      @(posedge clk); #2;
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL gate_blocked: %0d cycles busy or reading while disabled, required 0", viol);
    end
    fill_mem(1'b0);
    drain("gate_release", 1, 0, 0, 0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_enable_drop();
    int viol = 0;
    fill_mem(1'b0);
    drain("enable_drop", 1, 20, 0, 0, 0, 1'b0, 1'b1, -1);
    enable = 1'b0;
    buffer_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy !== 1'b0) viol++;
      @(posedge clk); #2;
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL enable_drop_block: %0d busy cycles after drop, required 0", viol);
    end
    drain("enable_restore", 1, 0, 0, 0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_overrun();
    fill_mem(1'b0);
    drain("overrun3", 1, 0, 0, 0, 3, 1'b0, 1'b0, -1);
    fill_mem(1'b0);
    drain("overrun_sat", 1, 0, 3, 620, 300, 1'b0, 1'b0, -1);
    fill_mem(1'b0);
    drain("overrun_hold", 1, 30, 0, 0, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      fill_mem(1'b0);
      drain("random", 1, $urandom_range(0, 60), 0, 0, $urandom_range(0, 3), 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_drain();
    int hs = 0;
    int acks = 0;
    fill_mem(1'b1);
    enable = 1'b1;
    buffer_ready = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      if (c == 1) buffer_ready = 1'b0;
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      @(posedge clk); #2;
    end
    checks++;
    if (hs != 2) begin
      failures++;
      $display("FAIL reset_mid_setup: got %0d handshakes required 2", hs);
    end
    buffer_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack) acks++;
      @(posedge clk); #2;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL reset_mid_ack: got %0d ack pulses required 0", acks);
    end
    exp_ovr = 0;
    rst_n = 1'b1;
    drain("reset_restart", 1, 0, 0, 0, 0, 1'b0, 1'b0, 3 * DEPTH);
  endtask

  task automatic test_back_to_back();
    fill_mem(1'b0);
    drain("b2b_first", 1, 0, 0, 0, 0, 1'b1, 1'b0, 3 * DEPTH);
    drain("b2b_second", 0, 0, 0, 0, 0, 1'b0, 1'b0, 3 * DEPTH);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gate();
    test_enable_drop();
    test_overrun();
    test_random();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
